// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous memory between
// the instruction-fetch and data load/store paths of a CPU core.
//
// state  | meaning
// IDLE   | wait for a request, arbitrate and register the transaction
// ACCESS | memory strobe driven for exactly one cycle
// WAIT   | read only: READ_LAT cycles, capture m_rdata when cnt==1
// RESP   | one-cycle valid pulse to the granted path
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [2:0] LAT = 3'(READ_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state, state_next;
  logic       last_i;
  logic       gnt_d;
  logic       op_wr;
  logic [2:0] cnt;
  logic       any_req;
  logic       sel_d;

  // last_i set means the previous grant went to fetch, so data wins a tie
  always_comb begin
    any_req = i_req | d_req;
    sel_d   = d_req & (~i_req | last_i);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = op_wr ? RESP : WAIT;
      WAIT:    if (cnt == 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_i  <= 1'b1;
      gnt_d   <= 1'b0;
      op_wr   <= 1'b0;
      cnt     <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_next;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d   <= sel_d;
            op_wr   <= sel_d & d_we;
            last_i  <= ~sel_d;
            m_addr  <= sel_d ? d_addr : i_addr;
            m_read  <= ~(sel_d & d_we);
            m_write <= sel_d & d_we;
            if (sel_d && d_we) m_wdata <= d_wdata;
          end
        end
        ACCESS: begin
          if (op_wr) d_valid <= 1'b1;
          else       cnt     <= LAT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (gnt_d) begin
              d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
